// File: rtl/upsamp2x.sv
// upsamp2x: nearest-neighbour 2x upsampler, (Length/2)^2 pooled raster in, LengthxLength raster out.
// Latency: first output beat one cycle after the first input transfer; one input per two output beats.
// Backpressure: out_ready low freezes data_out/out_last/state; in_ready follows out_ready combinationally.
module upsamp2x #(
  parameter int Length = 32,
  parameter int Width  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frame_done
);

  localparam int HALF = Length / 2;
  localparam int OCW  = $clog2(Length);
  localparam int ICW  = $clog2(HALF);
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(Length - 1);
  localparam logic [ICW-1:0] HALF_LAST = ICW'(HALF - 1);

  typedef enum logic {ROW_A, ROW_B} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [Width-1:0] linebuf [HALF];
  logic [Width-1:0] hold;
  logic             hold_valid;
  logic             phase;
  logic [ICW-1:0]   in_col;
  logic [ICW-1:0]   row_in;
  logic [OCW-1:0]   out_col;
  logic             done_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             row_end;

  // Handshake, output mux and next-state decode; outputs are forced idle while rst is high.
  // in_ready is also held low on the last beat of a pass row so the next row's first pixel
  // cannot land in the line buffer before that row has been replayed.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    data_out   = '0;
    if (!rst) begin
      if (state == ROW_A) begin
        in_ready  = !hold_valid || (phase && out_ready && (out_col != OCOL_LAST));
        out_valid = hold_valid;
        data_out  = hold_valid ? hold : '0;
      end else begin
        out_valid = 1'b1;
        data_out  = linebuf[out_col[OCW-1:1]];
      end
    end
    out_last   = out_valid && (out_col == OCOL_LAST);
    frame_done = done_q && !rst;
    in_xfer    = in_valid && in_ready;
    out_xfer   = out_valid && out_ready;
    row_end    = out_xfer && (out_col == OCOL_LAST);
    if (row_end) begin
      state_nxt = (state == ROW_A) ? ROW_B : ROW_A;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ROW_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Hold register, phase and raster counters; a same-cycle input reload beats the phase-1 drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      phase      <= 1'b0;
      in_col     <= '0;
      out_col    <= '0;
      row_in     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_xfer) begin
        hold       <= data_in;
        hold_valid <= 1'b1;
        phase      <= 1'b0;
        in_col     <= (in_col == HALF_LAST) ? '0 : in_col + 1'b1;
      end else if (out_xfer && (state == ROW_A)) begin
        if (phase) begin
          hold_valid <= 1'b0;
        end else begin
          phase <= 1'b1;
        end
      end
      if (out_xfer) begin
        out_col <= row_end ? '0 : out_col + 1'b1;
      end
      if (row_end && (state == ROW_A)) begin
        in_col <= '0;
      end
      if (row_end && (state == ROW_B)) begin
        if (row_in == HALF_LAST) begin
          row_in <= '0;
          done_q <= 1'b1;
        end else begin
          row_in <= row_in + 1'b1;
        end
      end
    end
  end

  // Line buffer capture of each pass-row pixel for the replay row; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      linebuf[in_col] <= data_in;
    end
  end

endmodule

// File: tb/tb_upsamp2x.sv
// Bench for upsamp2x: table vectors, directed corner sequences and randomized frames.
// Two instances (Length 4 and 32) share stimulus; sel32 picks which outputs are checked.
// Expected beats come from a pixel-replication model computed from frame contents.
module tb_upsamp2x;

  localparam int M_TOG  = 1;  // out_ready toggles 1,0,1,0
  localparam int M_RRDY = 2;  // random out_ready
  localparam int M_RVLD = 4;  // random in_valid gaps
  localparam int M_CONT = 8;  // continuous-stream checks (no mid-row drop, in_ready low on replay)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] data_in;
  logic        ir4, ov4, last4, fd4, ir32, ov32, last32, fd32;
  logic [15:0] do4, do32;

  upsamp2x #(.Length(4), .Width(16)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(ir4),
    .data_out(do4), .out_valid(ov4), .out_ready(out_ready), .out_last(last4), .frame_done(fd4));

  upsamp2x #(.Length(32), .Width(16)) dut32 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(ir32),
    .data_out(do32), .out_valid(ov32), .out_ready(out_ready), .out_last(last32), .frame_done(fd32));

  bit          sel32 = 1'b0;
  int          L = 4;
  logic        ir, ov, lst, fd;
  logic [15:0] dout;
  assign ir   = sel32 ? ir32   : ir4;
  assign ov   = sel32 ? ov32   : ov4;
  assign lst  = sel32 ? last32 : last4;
  assign fd   = sel32 ? fd32   : fd4;
  assign dout = sel32 ? do32   : do4;

  int          total = 0;
  int          bad = 0;
  int          in_q[$];
  logic [15:0] exp_d[$];
  bit          exp_l[$];
  int          frm[$];
  int          beat_idx = 0;
  bit          fd_exp = 1'b0;
  int          fd_cnt = 0;

  typedef struct {
    bit          in_en;
    logic [15:0] pix;
    logic [15:0] exp_dat;
    bit          exp_last;
  } vec_t;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (beat %0d, t=%0t)", name, act, req, beat_idx, $time);
    end
  endtask

  // Reference model: output beat (r,c) is pooled pixel (r/2, c/2); last on column L-1.
  task automatic add_frame();
    int h;
    h = L / 2;
    foreach (frm[i]) in_q.push_back(frm[i]);
    for (int r = 0; r < L; r++) begin
      for (int c = 0; c < L; c++) begin
        exp_d.push_back(16'(frm[(r / 2) * h + c / 2]));
        exp_l.push_back(c == L - 1);
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    data_in = 16'hBEEF;
    #1;
    chk(ov == 1'b0, "rst_out_valid", int'(ov), 0);
    chk(ir == 1'b0, "rst_in_ready", int'(ir), 0);
    chk(dout == 16'd0, "rst_data_out", int'(dout), 0);
    chk(lst == 1'b0, "rst_out_last", int'(lst), 0);
    chk(fd == 1'b0, "rst_frame_done", int'(fd), 0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    in_q.delete();
    exp_d.delete();
    exp_l.delete();
    beat_idx = 0;
    fd_exp = 1'b0;
    #1;
    chk(ov == 1'b0, "post_rst_out_valid", int'(ov), 0);
    chk(ir == 1'b1, "post_rst_in_ready", int'(ir), 1);
  endtask

  // One cycle per iteration: drive at negedge, sample 1 unit later, score transfers.
  task automatic run(input int max_cyc, input int stop_beats, input int mode, input int gap_at);
    int          cyc;
    int          beats;
    int          acc;
    int          gap;
    int          row;
    bit          prev_stall;
    bit          acc_prev;
    bit          tog;
    logic [15:0] pd;
    logic        pl;
    logic [15:0] ed;
    bit          el;
    cyc = 0; beats = 0; acc = 0; gap = 0;
    prev_stall = 1'b0; acc_prev = 1'b0; tog = 1'b1; pd = '0; pl = 1'b0;
    while (exp_d.size() > 0 && (stop_beats < 0 || beats < stop_beats) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if ((mode & M_TOG) != 0) begin
        out_ready = tog;
        tog = !tog;
      end else if ((mode & M_RRDY) != 0) begin
        out_ready = ($urandom_range(3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (in_q.size() > 0) && (gap == 0) &&
                 (((mode & M_RVLD) == 0) || ($urandom_range(3) != 0));
      data_in = in_valid ? 16'(in_q[0]) : 16'($urandom);
      #1;
      chk(fd == fd_exp, "frame_done", int'(fd), int'(fd_exp));
      if (fd) fd_cnt++;
      fd_exp = 1'b0;
      if (acc_prev) chk(ov == 1'b1, "first_beat_latency", int'(ov), 1);
      if (prev_stall) begin
        chk(ov == 1'b1, "stall_valid_hold", int'(ov), 1);
        chk(dout == pd, "stall_data_hold", int'(dout), int'(pd));
        chk(lst == pl, "stall_last_hold", int'(lst), int'(pl));
      end
      if (!ov) chk(dout == 16'd0, "idle_data_zero", int'(dout), 0);
      if ((mode & M_CONT) != 0 && (beat_idx % L) != 0)
        chk(ov == 1'b1, "no_midrow_drop", int'(ov), 1);
      if (ov && (mode & M_CONT) != 0) begin
        row = (beat_idx % (L * L)) / L;
        if (row % 2 == 1) chk(ir == 1'b0, "replay_in_ready_low", int'(ir), 0);
      end
      if (ov && out_ready) begin
        ed = exp_d.pop_front();
        el = exp_l.pop_front();
        chk(dout == ed, "beat_data", int'(dout), int'(ed));
        chk(lst == el, "beat_last", int'(lst), int'(el));
        beat_idx++;
        beats++;
        if (beat_idx % (L * L) == 0) fd_exp = 1'b1;
      end
      prev_stall = ov && !out_ready;
      pd = dout;
      pl = lst;
      acc_prev = in_valid && ir;
      if (gap > 0) gap--;
      if (in_valid && ir) begin
        void'(in_q.pop_front());
        acc++;
        if (acc == gap_at) gap = 3;
      end
    end
    chk(cyc < max_cyc, "timeout", cyc, max_cyc);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk(fd == fd_exp, "frame_done", int'(fd), int'(fd_exp));
      if (fd) fd_cnt++;
      fd_exp = 1'b0;
      chk(ov == 1'b0, "no_extra_beat", int'(ov), 0);
    end
  endtask

  task automatic load_frame4(input int a, input int b, input int c, input int d);
    frm.delete();
    frm.push_back(a); frm.push_back(b); frm.push_back(c); frm.push_back(d);
    add_frame();
  endtask

  initial begin
    vec_t tbl[16];
    int   ev[16];
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data_in = '0;

    // Length=4 table: inputs 1..4, expected beats with out_last on beats 3,7,11,15.
    ev = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
    for (int i = 0; i < 16; i++) begin
      tbl[i].in_en    = (i < 4);
      tbl[i].pix      = 16'(i + 1);
      tbl[i].exp_dat  = 16'(ev[i]);
      tbl[i].exp_last = ((i % 4) == 3);
    end

    sel32 = 1'b0; L = 4;
    do_reset(2);

    fd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].in_en) in_q.push_back(int'(tbl[i].pix));
      exp_d.push_back(tbl[i].exp_dat);
      exp_l.push_back(tbl[i].exp_last);
    end
    run(200, -1, 0, -1);
    settle(3);
    chk(fd_cnt == 1, "table_frame_done_count", fd_cnt, 1);

    // Continuous stream: no mid-row drop, in_ready low on replay rows.
    load_frame4(5, 6, 7, 8);
    run(200, -1, M_CONT, -1);
    settle(2);

    // out_ready toggling 1,0,1,0: stalled beats held, none lost or duplicated.
    load_frame4(1, 2, 3, 4);
    run(300, -1, M_TOG, -1);
    settle(2);

    // Three-cycle in_valid gap after the first pixel.
    load_frame4(1, 2, 3, 4);
    run(300, -1, 0, 1);
    settle(2);

    // Reset after 5 beats, then a fresh frame with no stale data.
    load_frame4(1, 2, 3, 4);
    run(200, 5, 0, -1);
    do_reset(2);
    load_frame4(9, 8, 7, 6);
    run(200, -1, 0, -1);
    settle(2);

    // Random pixels with random valid and ready, three back-to-back frames.
    fd_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      frm.delete();
      for (int i = 0; i < 4; i++) frm.push_back(int'($urandom_range(65535)));
      add_frame();
    end
    run(2000, -1, M_RRDY | M_RVLD, -1);
    settle(2);
    chk(fd_cnt == 3, "rand4_frame_done_count", fd_cnt, 3);

    // Length=32: two back-to-back frames of pixels 0..255 at full rate.
    sel32 = 1'b1; L = 32;
    do_reset(2);
    fd_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      frm.delete();
      for (int i = 0; i < 256; i++) frm.push_back(i);
      add_frame();
    end
    run(6000, -1, M_CONT, -1);
    settle(2);
    chk(fd_cnt == 2, "len32_frame_done_count", fd_cnt, 2);

    // Length=32 random frame under random backpressure.
    frm.delete();
    for (int i = 0; i < 256; i++) frm.push_back(int'($urandom_range(65535)));
    add_frame();
    run(8000, -1, M_RRDY | M_RVLD, -1);
    settle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
